bpred_unit: RTL
===============

# bpred_unit

Parametrised branch prediction unit for the MIPS pipeline. It replaces the direct-mapped, tagless next-PC table with three parts: a tagged branch target buffer, 2-bit saturating direction counters and a return-address stack (RAS). Lookup takes the IF-stage PC and delivers a prediction in the following (IG) stage. Resolved control-flow information from the WA stage trains the tables.

## Interface
Parameters:
- `PC_W`, 30: word-address PC width (byte address = {pc, 2'b00}).
- `IDX_W`, 10: BTB index bits; the table has 2**IDX_W entries.
- `TAG_W`, 8: tag bits, taken from pc[IDX_W +: TAG_W]; IDX_W+TAG_W <= PC_W.
- `RAS_DEPTH`, 8: number of RAS entries; must be a power of two, >= 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous, active-low; the block is in reset when rst==0 is sampled at a posedge.
- `lk_pc`, in, PC_W: lookup PC, presented every cycle (IF).
- `pred_hit`, out, 1: a BTB entry matched lk_pc of the previous cycle.
- `pred_taken`, out, 1: the predicted direction.
- `pred_pc`, out, PC_W: the predicted next PC.
- `upd_en`, in, 1: one resolved control-flow instruction is presented this cycle (WA, valid only).
- `upd_pc`, in, PC_W: PC of the resolved instruction.
- `upd_kind`, in, 2: 0 = conditional (beq/bne), 1 = jump (j / jr not $31), 2 = call (jal), 3 = return (jr $31).
- `upd_taken`, in, 1: the actual direction; the unit treats kinds 1–3 as taken regardless of this input.
- `upd_target`, in, PC_W: the actual taken target.
- `init_busy`, out, 1: the table clear sweep is in progress.

## Operation
- **Entry contents:** {valid, tag[TAG_W], kind[2], ctr[2], target[PC_W]}.
- **Clear FSM, states CLEAR and READY:**
  - Reset sends the FSM to CLEAR with clr_idx=0.
  - In CLEAR, the unit writes valid=0 at clr_idx and increments clr_idx each cycle.
  - When clr_idx == 2**IDX_W-1, the FSM goes to READY.
  - init_busy = (state==CLEAR).
  - While CLEAR, upd_en is ignored and the lookup outputs are forced to hit=0, taken=0, pred_pc=lk_pc+1.
- **Lookup:** idx = lk_pc[0 +: IDX_W]; hit = valid && tag equal.
  - Miss: taken=0, pred_pc = lk_pc+1 (mod 2**PC_W).
  - Hit, kind 0: taken = ctr[1]; pred_pc = taken ? target : lk_pc+1.
  - Hit, kind 1 or 2: taken=1, pred_pc = target.
  - Hit, kind 3: taken=1; pred_pc = RAS top when ras_cnt>0, otherwise the stored target.
- **Update on an existing entry** (upd_en in READY, tag hit at idx of upd_pc):
  - kind 0: ctr increments if taken, decrements if not; it saturates at 3 and at 0. target <= upd_target only when taken.
  - kinds 1–3: target <= upd_target. kind field <= upd_kind.
- **Update that misses the BTB:**
  - Allocate (overwrite the index) only if the instruction was effectively taken (kind!=0 or upd_taken).
  - The new entry gets valid=1, the new tag, kind, ctr=2 (weakly taken) and target.
  - A not-taken conditional is never allocated.
- **RAS (trained at commit, non-speculative):**
  - kind 2: push upd_pc+1. When full, the push overwrites the oldest entry (circular pointer) and ras_cnt stays at RAS_DEPTH.
  - kind 3: pop if ras_cnt>0; with ras_cnt==0 it is a no-op.
  - The RAS top is the entry at ptr-1 (mod RAS_DEPTH).
- **Reset values:** pred_hit=0, pred_taken=0, pred_pc=0, init_busy=1 from the first cycle after reset, ras_cnt=0, ras ptr=0, ctr/target contents don't-care (valid cleared by the sweep).

## Timing
- **Lookup latency:** 1 cycle. lk_pc sampled at edge n produces outputs valid after edge n until edge n+1, matching the synchronous-read memory behaviour.
- **Update:** the write occurs at the edge where upd_en is sampled. A lookup of the same index sampled at that same edge sees the old entry (read-first); the next lookup sees the new one.
- **RAS:** a push/pop at edge n is visible to a lookup sampled at edge n+1. A lookup sampled at edge n uses the pre-update top.
- **Clear sweep:** lasts exactly 2**IDX_W cycles after reset deasserts. Reset asserted mid-sweep restarts the sweep at index 0.
- **Reset during READY:** a fresh sweep runs. Outputs return to their reset values the cycle after rst is sampled low.
- **Aliasing:** different PCs with equal idx and tag alias silently. That is a performance effect only.

## Test plan
Bench parameters: IDX_W=4, TAG_W=4, RAS_DEPTH=4.
- **Reset and clear:** hold rst=0 for 2 cycles, then release. Required: init_busy=1 for exactly 16 cycles. During that window, lk_pc=0x10 gives pred_hit=0, pred_pc=0x11. An upd_en pulse at cycle 5 leaves no entry: a later lookup of its PC misses.
- **Counter training:** run update kind0, pc=0x23, taken, target=0x40 (allocated, ctr=2).
  - Lookup 0x23 must return hit=1, taken=1, pred_pc=0x40.
  - Two not-taken updates must give taken=0, pred_pc=0x24.
  - A third not-taken update must keep ctr=0, and one taken update after it must still predict not-taken.
- **Not-taken allocation:** update kind0 pc=0x35 not-taken on an empty slot, then look up 0x35. Required: hit=0.
- **Tag mismatch:** after allocating 0x23, look up 0x13 (same idx, different tag). Required: hit=0, pred_pc=0x14.
- **RAS:** train return pc=0x50 (kind3, target 0x99) while the RAS is empty. Then push calls from 0x10, 0x20, 0x30, 0x40, 0x60.
  - Required: 0x11 is overwritten; successive pop+lookup sequences at 0x50 predict 0x61, 0x41, 0x31, 0x21.
  - After that, the RAS is empty and the lookup predicts 0x99.
- **Same-cycle update and lookup:** update idx 3 to target 0x70 at the same edge as a lookup of that pc. Required: the lookup returns the old prediction, and the following lookup returns 0x70.

Source files
------------

// File: rtl/bpred_if.sv
`default_nettype none
// ============================================================================
// Module   : bpred_if
// Brief    : Lookup / training bundle between the pipeline and bpred_unit.
//            master = pipeline side, slave = prediction unit.
// Revision : 1.0 - initial release
// ============================================================================
interface bpred_if #(
  parameter int PC_W = 30
);
  // IF-stage lookup and IG-stage prediction
  logic [PC_W-1:0] lk_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;

  // WA-stage resolved control flow
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic [1:0]      upd_kind;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  // table clear sweep status
  logic            init_busy;

  modport master (
    output lk_pc, upd_en, upd_pc, upd_kind, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_pc, init_busy
  );

  modport slave (
    input  lk_pc, upd_en, upd_pc, upd_kind, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_pc, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/bpred_unit.sv
`default_nettype none
// ============================================================================
// Module   : bpred_unit
// Brief    : Tagged BTB with 2-bit direction counters and a commit-trained
//            return-address stack. Lookup result one cycle after lk_pc.
// Revision : 1.0 - initial release
// ============================================================================
module bpred_unit #(
  parameter int PC_W      = 30,
  parameter int IDX_W     = 10,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  bpred_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = RAS_W + 1;

  localparam logic [1:0]       KIND_COND = 2'd0;
  localparam logic [1:0]       KIND_JUMP = 2'd1;
  localparam logic [1:0]       KIND_CALL = 2'd2;
  localparam logic [1:0]       KIND_RET  = 2'd3;
  localparam logic [CNT_W-1:0] RAS_FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // BTB storage; only the valid bits are ever cleared
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [1:0]       kind_mem   [DEPTH];
  logic [1:0]       ctr_mem    [DEPTH];
  logic [PC_W-1:0]  target_mem [DEPTH];

  // return-address stack: circular buffer, ptr is the next free slot
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr_q;
  logic [CNT_W-1:0] ras_cnt_q;
  logic [RAS_W-1:0] ras_top_idx;
  logic [PC_W-1:0]  ras_top;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [PC_W-1:0]  lk_seq;
  logic             hit_d, taken_d;
  logic [PC_W-1:0]  pc_d;
  logic             hit_q, taken_q;
  logic [PC_W-1:0]  pc_q;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_eff_taken;
  logic             upd_go;
  logic [1:0]       upd_ctr_old;
  logic [1:0]       upd_ctr_new;

  // clear FSM state register; reset restarts the sweep at index 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // clear FSM next state: walk every index once, then serve predictions
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (&clr_idx_q) begin
          state_d = READY;
        end
      end
      default: begin
      end
    endcase
  end

  assign lk_idx      = bus.lk_pc[0 +: IDX_W];
  assign lk_tag      = bus.lk_pc[IDX_W +: TAG_W];
  assign lk_hit      = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_seq      = bus.lk_pc + 1'b1;
  assign ras_top_idx = ras_ptr_q - 1'b1;
  assign ras_top     = ras_mem[ras_top_idx];

  // prediction for the current lookup; tables are read before this edge's writes
  always_comb begin
    hit_d   = 1'b0;
    taken_d = 1'b0;
    pc_d    = lk_seq;
    if (state_q == READY && lk_hit) begin
      hit_d = 1'b1;
      case (kind_mem[lk_idx])
        KIND_COND: begin
          taken_d = ctr_mem[lk_idx][1];
          if (ctr_mem[lk_idx][1]) begin
            pc_d = target_mem[lk_idx];
          end
        end
        KIND_RET: begin
          taken_d = 1'b1;
          pc_d    = (ras_cnt_q != '0) ? ras_top : target_mem[lk_idx];
        end
        default: begin
          taken_d = 1'b1;
          pc_d    = target_mem[lk_idx];
        end
      endcase
    end
  end

  // IG-stage prediction register
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      taken_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      hit_q   <= hit_d;
      taken_q <= taken_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pred_hit   = hit_q;
  assign bus.pred_taken = taken_q;
  assign bus.pred_pc    = pc_q;
  assign bus.init_busy  = (state_q == CLEAR);

  assign upd_idx       = bus.upd_pc[0 +: IDX_W];
  assign upd_tag       = bus.upd_pc[IDX_W +: TAG_W];
  assign upd_hit       = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign upd_eff_taken = (bus.upd_kind != KIND_COND) || bus.upd_taken;
  assign upd_go        = rst && bus.upd_en && (state_q == READY);
  assign upd_ctr_old   = ctr_mem[upd_idx];

  // saturating 2-bit direction counter step
  always_comb begin
    upd_ctr_new = upd_ctr_old;
    if (bus.upd_taken) begin
      if (upd_ctr_old != 2'b11) upd_ctr_new = upd_ctr_old + 2'b01;
    end else begin
      if (upd_ctr_old != 2'b00) upd_ctr_new = upd_ctr_old - 2'b01;
    end
  end

  // BTB write port: clear sweep, train on hit, allocate effectively-taken misses
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      valid_q[clr_idx_q] <= 1'b0;
    end else if (upd_go) begin
      if (upd_hit) begin
        if (bus.upd_kind == KIND_COND) begin
          ctr_mem[upd_idx] <= upd_ctr_new;
          if (bus.upd_taken) target_mem[upd_idx] <= bus.upd_target;
        end else begin
          target_mem[upd_idx] <= bus.upd_target;
          kind_mem[upd_idx]   <= bus.upd_kind;
        end
      end else if (upd_eff_taken) begin
        valid_q[upd_idx]    <= 1'b1;
        tag_mem[upd_idx]    <= upd_tag;
        kind_mem[upd_idx]   <= bus.upd_kind;
        ctr_mem[upd_idx]    <= 2'b10;
        target_mem[upd_idx] <= bus.upd_target;
      end
    end
  end

  // RAS data: a call writes its return address into the next slot
  always_ff @(posedge clk) begin
    if (upd_go && bus.upd_kind == KIND_CALL) begin
      ras_mem[ras_ptr_q] <= bus.upd_pc + 1'b1;
    end
  end

  // RAS pointer/count: full pushes overwrite the oldest, empty pops do nothing
  always_ff @(posedge clk) begin
    if (!rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (upd_go) begin
      case (bus.upd_kind)
        KIND_CALL: begin
          ras_ptr_q <= ras_ptr_q + 1'b1;
          if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + 1'b1;
        end
        KIND_RET: begin
          if (ras_cnt_q != '0) begin
            ras_ptr_q <= ras_ptr_q - 1'b1;
            ras_cnt_q <= ras_cnt_q - 1'b1;
          end
        end
        KIND_JUMP, KIND_COND: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
